warmboot_sequencer: RTL and testbench

- Sits between the bootloader core's `boot` output and the SB_WARMBOOT primitive and USB pull-up pin on the board top.
- On a boot request it waits for the USB transmitter to go idle, then drops the D+ pull-up so the host sees a clean detach.
- It holds the detach for a programmable time, then asserts the warmboot pulse with a latched image select.
- It replaces the direct `boot`-to-BOOT connection and the constant `pin_pu` tie.

---
 rtl/warmboot_sequencer_if.sv | 22 ++
 rtl/warmboot_sequencer.sv | 92 +++++++++
 tb/tb_warmboot_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/warmboot_sequencer_if.sv
// rtl/warmboot_sequencer_if.sv - boot request and SB_WARMBOOT / pull-up signal bundle
interface warmboot_sequencer_if;
  logic       boot_req;
  logic [1:0] image_sel;
  logic       usb_tx_en;
  logic       pu_en;
  logic       wb_s1;
  logic       wb_s0;
  logic       wb_boot;
  logic       busy;

  // master: bootloader core side; slave: the sequencer
  modport master (
    output boot_req, image_sel, usb_tx_en,
    input  pu_en, wb_s1, wb_s0, wb_boot, busy
  );

  modport slave (
    input  boot_req, image_sel, usb_tx_en,
    output pu_en, wb_s1, wb_s0, wb_boot, busy
  );
endinterface

// File: rtl/warmboot_sequencer.sv
// rtl/warmboot_sequencer.sv - drains USB tx, detaches D+ pull-up, then fires SB_WARMBOOT
module warmboot_sequencer #(
  parameter int         DRAIN_IDLE_CYCLES = 48,
  parameter int         DETACH_CYCLES     = 480000,
  parameter logic [1:0] DEFAULT_IMAGE     = 2'b01
) (
  input  logic                  clk_48mhz,
  input  logic                  reset_n,
  warmboot_sequencer_if.slave   bus
);

  localparam int MAX_CYCLES = (DRAIN_IDLE_CYCLES > DETACH_CYCLES) ? DRAIN_IDLE_CYCLES : DETACH_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DETACH_LAST = CNT_W'(DETACH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    DETACH,
    ARM,
    FIRE
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] counter, counter_d;
  logic [1:0]       image, image_d;
  logic             boot_req_q;
  logic             req_edge;

  // boot_req_q resets high so a request already asserted at reset release is not an edge
  assign req_edge = bus.boot_req && !boot_req_q;

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      counter    <= '0;
      image      <= DEFAULT_IMAGE;
      boot_req_q <= 1'b1;
    end else begin
      state      <= state_d;
      counter    <= counter_d;
      image      <= image_d;
      boot_req_q <= bus.boot_req;
    end
  end

  always_comb begin
    state_d   = state;
    counter_d = counter;
    image_d   = image;
    case (state)
      IDLE: begin
        if (req_edge) begin
          image_d   = bus.image_sel;
          counter_d = '0;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        // any transmit activity restarts the idle window, even on the terminal cycle
        if (bus.usb_tx_en) begin
          counter_d = '0;
        end else if (counter == DRAIN_LAST) begin
          counter_d = '0;
          state_d   = DETACH;
        end else begin
          counter_d = counter + CNT_ONE;
        end
      end
      DETACH: begin
        if (counter == DETACH_LAST) begin
          state_d = ARM;
        end else begin
          counter_d = counter + CNT_ONE;
        end
      end
      ARM:     state_d = FIRE;
      FIRE:    state_d = FIRE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.pu_en   = (state == IDLE) || (state == DRAIN);
  assign bus.wb_boot = (state == FIRE);
  assign bus.busy    = (state != IDLE);
  assign bus.wb_s1   = image[1];
  assign bus.wb_s0   = image[0];

endmodule

// File: tb/tb_warmboot_sequencer.sv
// tb/tb_warmboot_sequencer.sv - scoreboard bench: expected output-change events vs observed
module tb_warmboot_sequencer;

  localparam int DRAIN  = 4;
  localparam int DETACH = 16;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];

  warmboot_sequencer_if bus ();

  warmboot_sequencer #(
    .DRAIN_IDLE_CYCLES (DRAIN),
    .DETACH_CYCLES     (DETACH),
    .DEFAULT_IMAGE     (2'b01)
  ) dut (
    .clk_48mhz (clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // observed vector: {busy, pu_en, wb_boot, wb_s1, wb_s0}
  logic [4:0] prev = 5'bxxxxx;
  always @(negedge clk) begin
    logic [4:0] cur;
    ev_t e;
    cur = {bus.busy, bus.pu_en, bus.wb_boot, bus.wb_s1, bus.wb_s0};
    if (cur !== prev) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e.vec || (e.cyc >= 0 && cyc != e.cyc)) begin
          n_bad++;
          $display("FAIL output_event got=%b@%0d required=%b@%0d", cur, cyc, e.vec, e.cyc);
        end
      end
      prev = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic [4:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  // low-then-high request; returns accepting edge E, and returns with cyc == E
  task automatic request(input logic [1:0] img, output int e);
    bus.boot_req = 1'b0;
    tick(1);
    bus.boot_req  = 1'b1;
    bus.image_sel = img;
    e = cyc + 1;
    tick(1);
  endtask

  int e;

  initial begin
    // held request and request edge during reset must not start a sequence
    reset_n       = 1'b0;
    bus.boot_req  = 1'b1;
    bus.image_sel = 2'b10;
    bus.usb_tx_en = 1'b0;
    push(-1, 5'b01001);
    tick(2);
    bus.boot_req = 1'b0;
    tick(1);
    bus.boot_req = 1'b1;
    tick(1);
    reset_n = 1'b1;
    tick(5);

    // nominal, with ignored request/image/tx activity during DETACH, then terminal hold
    request(2'b10, e);
    push(e,              5'b11010);
    push(e + DRAIN,      5'b10010);
    push(e + DRAIN + DETACH + 1, 5'b10110);
    tick(8);
    bus.boot_req = 1'b0;
    tick(1);
    bus.boot_req  = 1'b1;
    bus.image_sel = 2'b11;
    for (int i = 0; i < 8; i++) begin
      bus.usb_tx_en = ~bus.usb_tx_en;
      tick(1);
    end
    bus.usb_tx_en = 1'b0;
    tick(5);
    for (int i = 0; i < 100; i++) begin
      bus.boot_req  = 1'($urandom_range(0, 1));
      bus.usb_tx_en = 1'($urandom_range(0, 1));
      tick(1);
    end

    // reset out of FIRE
    bus.boot_req  = 1'b0;
    bus.usb_tx_en = 1'b0;
    push(cyc, 5'b01001);
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // tx pulse on the would-be terminal DRAIN cycle, then reset at DETACH count 8
    request(2'b10, e);
    push(e,      5'b11010);
    push(e + 8,  5'b10010);
    push(e + 16, 5'b01001);
    tick(3);
    bus.usb_tx_en = 1'b1;
    tick(1);
    bus.usb_tx_en = 1'b0;
    tick(12);
    bus.boot_req = 1'b0;
    reset_n      = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // continuous tx holds off detach; idle window starts once tx drops
    bus.usb_tx_en = 1'b1;
    request(2'b11, e);
    push(e,      5'b11011);
    push(e + 64, 5'b10011);
    push(e + 81, 5'b10111);
    tick(60);
    bus.usb_tx_en = 1'b0;
    tick(25);

    // reset then a full rerun of DRAIN+DETACH timing
    bus.boot_req = 1'b0;
    push(cyc, 5'b01001);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    request(2'b00, e);
    push(e,                      5'b11000);
    push(e + DRAIN,              5'b10000);
    push(e + DRAIN + DETACH + 1, 5'b10100);
    tick(30);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events got=%0d pending required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
